// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the 8-bit byte bus between the instruction-fetch port
// and the data port. It serialises one 32-bit address (ADDR_BYTES bytes) and
// either 4 write bytes or 4 read bytes. It also gathers the read bytes into rdata.
// Build option: define IO_ARB_RR_EN for round-robin tie-breaking; otherwise the
// data port always wins a simultaneous request.
module io_bus_arbiter #(
  parameter int unsigned ADDR_BYTES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_done,
  output logic [31:0] rdata,
  input  logic [7:0]  bus_in,
  output logic [7:0]  bus_addr,
  output logic [7:0]  bus_data,
  output logic        bus_dir,
  output logic        busy
);

  if (ADDR_BYTES < 1 || ADDR_BYTES > 4) begin : g_bad_addr_bytes
    $error("io_bus_arbiter: ADDR_BYTES must be in 1..4");
  end

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StTurn,
    StRead,
    StWrite,
    StDone
  } state_e;

  localparam logic [2:0] AddrLast = 3'(ADDR_BYTES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        owner_q;   // 1 = data port owns the current transaction
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        any_req;
  logic        pick_d;    // 1 = data port is granted this IDLE cycle
  logic [4:0]  byte_sel;

  assign any_req  = i_req | d_req;
  assign byte_sel = {cnt_q[1:0], 3'b000};

`ifdef IO_ARB_RR_EN
  logic last_d_q;         // 1 = data port was the most recent owner

  // Tie goes to whichever port did not own the bus last.
  always_comb begin
    pick_d = d_req;
    if (i_req && d_req) begin
      pick_d = ~last_d_q;
    end
  end

  // Remember the last owner at every grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d_q <= 1'b0;
    end else if (state_q == StIdle && any_req) begin
      last_d_q <= pick_d;
    end
  end
`else
  // Fixed priority: data port wins any tie.
  assign pick_d = d_req;
`endif

  // Next-state and byte counter; cnt restarts from 0 on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 3'd1;
    unique case (state_q)
      StIdle: begin
        cnt_d = 3'd0;
        if (any_req) begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        if (cnt_q == AddrLast) begin
          state_d = we_q ? StWrite : StTurn;
        end
      end
      StTurn:  state_d = StRead;
      StRead:  if (cnt_q == 3'd3) state_d = StDone;
      StWrite: if (cnt_q == 3'd3) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (state_d != state_q) begin
      cnt_d = 3'd0;
    end
  end

  // Read-byte capture into the little-endian read word.
  always_comb begin
    rdata_d = rdata_q;
    if (state_q == StRead) begin
      rdata_d[byte_sel +: 8] = bus_in;
    end
  end

  // State, counter and read word registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Latch owner and its request fields when a transaction starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
    end else if (state_q == StIdle && any_req) begin
      owner_q <= pick_d;
      we_q    <= pick_d & d_we;
      addr_q  <= pick_d ? d_addr : i_addr;
      wdata_q <= d_wdata;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus_addr = 8'h00;
    bus_data = 8'h00;
    bus_dir  = 1'b0;
    i_done   = 1'b0;
    d_done   = 1'b0;
    busy     = (state_q != StIdle);
    i_gnt    = busy & ~owner_q;
    d_gnt    = busy & owner_q;
    unique case (state_q)
      StIdle: ;
      StAddr: bus_addr = addr_q[byte_sel +: 8];
      StTurn: bus_addr = 8'hFF;
      StRead: begin
        bus_addr = 8'hFF;
        bus_dir  = 1'b1;
      end
      StWrite: begin
        bus_addr = 8'hFE;
        bus_data = wdata_q[byte_sel +: 8];
      end
      StDone: begin
        i_done = ~owner_q;
        d_done = owner_q;
      end
      default: ;
    endcase
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: a scoreboard of expected completions
// (port, latency, read word) is filled as requests are driven and drained on done.
module tb_io_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_done, d_gnt, d_done, bus_dir, busy;
  logic [31:0] rdata;
  logic [7:0]  bus_in, bus_addr, bus_data;

  // Second instance with a 2-byte address phase.
  logic        d2_req, d2_we;
  logic [31:0] d2_addr;
  logic        i2_gnt, i2_done, d2_gnt, d2_done, bus_dir2, busy2;
  logic [31:0] rdata2;
  logic [7:0]  bus_addr2, bus_data2;

  io_bus_arbiter dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_done(d_done), .rdata(rdata), .bus_in(bus_in), .bus_addr(bus_addr),
    .bus_data(bus_data), .bus_dir(bus_dir), .busy(busy)
  );

  io_bus_arbiter #(.ADDR_BYTES(2)) dut2 (
    .clk(clk), .rst(rst), .i_req(1'b0), .i_addr(32'h0), .i_gnt(i2_gnt), .i_done(i2_done),
    .d_req(d2_req), .d_we(d2_we), .d_addr(d2_addr), .d_wdata(32'h0), .d_gnt(d2_gnt),
    .d_done(d2_done), .rdata(rdata2), .bus_in(bus_in), .bus_addr(bus_addr2),
    .bus_data(bus_data2), .bus_dir(bus_dir2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_d;
    int          start;
    int          lat;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_d, input int start, input int lat, input logic [31:0] rd);
    exp_t e;
    e.is_d  = is_d;
    e.start = start;
    e.lat   = lat;
    e.rd    = rd;
    sb.push_back(e);
  endtask

  // Completion monitor: every done must match the oldest expected transaction.
  exp_t m;
  always @(negedge clk) begin
    if (rst) begin
      if (i_gnt && d_gnt) check("gnt_exclusive", 32'(i_gnt & d_gnt), 32'h0);
      if (i_done || d_done) begin
        check("done_exclusive", 32'(i_done & d_done), 32'h0);
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(d_done), 32'(i_done));
          check("unexpected_done_any", 32'h1, 32'(sb.size()));
        end else begin
          m = sb.pop_front();
          check("done_port", 32'(d_done), 32'(m.is_d));
          check("done_cycle", 32'(cyc - m.start), 32'(m.lat));
          check("rdata_at_done", rdata, m.rd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

  logic [7:0] ia_exp [4] = '{8'h34, 8'h12, 8'h00, 8'h00};
  logic [7:0] rb     [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
  logic [7:0] da_exp [4] = '{8'h10, 8'h00, 8'h00, 8'h00};
  logic [7:0] wb     [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

  initial begin
    int got;
    rst = 1'b0;
    i_req = 0; d_req = 0; d_we = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; bus_in = 0;
    d2_req = 0; d2_we = 0; d2_addr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bus_addr", 32'(bus_addr), 32'h0);
    check("rst_bus_data", 32'(bus_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_gnt", 32'({i_gnt, d_gnt}), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_dir", 32'(bus_dir), 32'h0);
    rst = 1'b1;

    // Instruction read.
    tick();
    i_addr = 32'h0000_1234;
    i_req  = 1'b1;
    push(1'b0, cyc, 10, 32'h1234_5678);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) i_req = 1'b0;
      bus_in = (k >= 6 && k <= 9) ? rb[k-6] : 8'h00;
      @(negedge clk);
      if (k <= 4) check("iread_addr_byte", 32'(bus_addr), 32'(ia_exp[k-1]));
      if (k == 5) check("iread_turn", 32'(bus_addr), 32'hFF);
      if (k >= 6 && k <= 9) check("iread_dir", 32'(bus_dir), 32'h1);
      check("iread_d_gnt", 32'(d_gnt), 32'h0);
    end
    tick();
    @(negedge clk);
    check("iread_idle", 32'(busy), 32'h0);

    // Data write.
    tick();
    d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; d_we = 1'b1; d_req = 1'b1;
    push(1'b1, cyc, 9, 32'h1234_5678);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) d_req = 1'b0;
      @(negedge clk);
      if (k <= 4) check("dwrite_addr_byte", 32'(bus_addr), 32'(da_exp[k-1]));
      if (k >= 5 && k <= 8) begin
        check("dwrite_marker", 32'(bus_addr), 32'hFE);
        check("dwrite_data", 32'(bus_data), 32'(wb[k-5]));
      end
      check("dwrite_i_gnt", 32'(i_gnt), 32'h0);
    end
    d_we = 1'b0;

    // Tie arbitration across 4 back-to-back reads, starting fresh from reset.
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    tick();
    i_addr = 32'h100; d_addr = 32'h200; bus_in = 8'hA5;
    i_req = 1'b1; d_req = 1'b1;
    for (int n = 0; n < 4; n++) begin
`ifdef IO_ARB_RR_EN
      push((n % 2) == 0, cyc + 11 * n, 10, 32'hA5A5_A5A5);
`else
      push(1'b1, cyc + 11 * n, 10, 32'hA5A5_A5A5);
`endif
    end
    repeat (43) tick();
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("tie_idle", 32'(busy), 32'h0);

    // Reset in the third READ cycle, then restart with i_req held.
    tick();
    i_addr = 32'hCAFE_0001; i_req = 1'b1; bus_in = 8'h11;
    repeat (8) tick();
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_gnt", 32'({i_gnt, d_gnt}), 32'h0);
    check("midrst_done", 32'({i_done, d_done}), 32'h0);
    check("midrst_bus", 32'({bus_addr, bus_data, 7'h0, bus_dir}), 32'h0);
    check("midrst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    bus_in = 8'h3C;
    push(1'b0, cyc, 10, 32'h3C3C_3C3C);
    tick();
    @(negedge clk);
    check("restart_byte0", 32'(bus_addr), 32'h01);
    check("restart_i_gnt", 32'(i_gnt), 32'h1);
    i_req = 1'b0;
    repeat (10) tick();

    // i_req dropped during ADDR: one done, then the bus stays idle.
    tick();
    i_addr = 32'h40; i_req = 1'b1;
    push(1'b0, cyc, 10, 32'h3C3C_3C3C);
    repeat (2) tick();
    i_req = 1'b0;
    repeat (9) tick();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("drop_idle", 32'(busy), 32'h0);
      tick();
    end

    // ADDR_BYTES = 2 data read.
    tick();
    d2_addr = 32'h0000_5678; d2_we = 1'b0; d2_req = 1'b1; bus_in = 8'h9A;
    got = -1;
    for (int k = 1; k <= 20 && got < 0; k++) begin
      tick();
      if (k == 1) d2_req = 1'b0;
      @(negedge clk);
      if (k == 1) check("ab2_addr0", 32'(bus_addr2), 32'h78);
      if (k == 2) check("ab2_addr1", 32'(bus_addr2), 32'h56);
      if (k == 3) check("ab2_turn", 32'(bus_addr2), 32'hFF);
      if (d2_done) got = k;
    end
    check("ab2_done_cycle", 32'(got), 32'd8);
    check("ab2_rdata", rdata2, 32'h9A9A_9A9A);

    tick();
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
